// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache between the LSU and a
// single-outstanding memory port. Hits answer in one cycle; misses refill a whole line.
module cache_dm_wt #(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_v,
  input  logic              w_v,
  input  logic [31:0]       adr,
  input  logic [XLEN-1:0]   data,
  input  logic [XLEN/8-1:0] strobe,
  output logic [XLEN-1:0]   resp,
  output logic              ack,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [31:0]       m_adr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_strobe,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata
);
  localparam int NB = XLEN / 8;
  localparam int BO = $clog2(NB);
  localparam int WO = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - BO - WO - IW;

  typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_WAIT, WT_REQ, RESP} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_mem_q  [LINES];
  logic [XLEN-1:0]   data_mem_q [LINES*LINE_WORDS];

  logic [IW-1:0]     idx_q;
  logic [TW-1:0]     tag_q;
  logic [WO-1:0]     wo_q, cnt_q;
  logic              ack_q, err_q, m_req_q, m_we_q;
  logic [XLEN-1:0]   resp_q, m_wdata_q;
  logic [31:0]       m_adr_q;
  logic [NB-1:0]     m_strobe_q;

  logic [IW-1:0]     in_idx;
  logic [TW-1:0]     in_tag;
  logic [WO-1:0]     in_wo, cnt_nxt;
  logic              in_hit, q_hit, misaligned;
  logic              refill_we, refill_last, wt_we;
  logic [XLEN-1:0]   wt_word_d;

  assign in_idx     = adr[BO+WO +: IW];
  assign in_tag     = adr[31 -: TW];
  assign in_wo      = adr[BO +: WO];
  assign misaligned = (adr & 32'(NB-1)) != '0;
  assign in_hit     = valid_q[in_idx] && (tag_mem_q[in_idx] == in_tag);
  assign q_hit      = valid_q[idx_q] && (tag_mem_q[idx_q] == tag_q);
  assign cnt_nxt    = cnt_q + 1'b1;

  // Array writes are gated by rst so an abandoned transaction leaves no trace.
  assign refill_we   = !rst && (state_q == REFILL_WAIT) && m_rvalid;
  assign refill_last = refill_we && (cnt_q == WO'(LINE_WORDS-1));
  assign wt_we       = !rst && (state_q == WT_REQ) && m_gnt && q_hit;

  always_comb begin
    wt_word_d = data_mem_q[{idx_q, wo_q}];
    for (int b = 0; b < NB; b++)
      if (m_strobe_q[b]) wt_word_d[8*b +: 8] = m_wdata_q[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (refill_we)   data_mem_q[{idx_q, cnt_q}] <= m_rdata;
    if (wt_we)       data_mem_q[{idx_q, wo_q}]  <= wt_word_d;
    if (refill_last) tag_mem_q[idx_q]           <= tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      wo_q       <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      resp_q     <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_adr_q    <= '0;
      m_wdata_q  <= '0;
      m_strobe_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The ack cycle itself never accepts, so a held request is seen once more only afterwards.
          if ((r_v || w_v) && !ack_q) begin
            idx_q <= in_idx;
            tag_q <= in_tag;
            wo_q  <= in_wo;
            if ((r_v && w_v) || misaligned) begin
              ack_q  <= 1'b1;
              err_q  <= 1'b1;
              resp_q <= '0;
            end else if (r_v) begin
              if (in_hit) begin
                ack_q  <= 1'b1;
                resp_q <= data_mem_q[{in_idx, in_wo}];
              end else begin
                state_q <= REFILL_REQ;
                cnt_q   <= '0;
                m_req_q <= 1'b1;
                m_we_q  <= 1'b0;
                m_adr_q <= 32'({in_tag, in_idx, {WO{1'b0}}}) << BO;
              end
            end else if (strobe == '0) begin
              ack_q  <= 1'b1;
              resp_q <= '0;
            end else begin
              state_q    <= WT_REQ;
              m_req_q    <= 1'b1;
              m_we_q     <= 1'b1;
              m_adr_q    <= adr;
              m_wdata_q  <= data;
              m_strobe_q <= strobe;
            end
          end
        end
        REFILL_REQ: begin
          if (m_gnt) begin
            m_req_q <= 1'b0;
            state_q <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (m_rvalid) begin
            cnt_q <= cnt_nxt;
            if (cnt_q == wo_q) resp_q <= m_rdata;
            if (cnt_q == WO'(LINE_WORDS-1)) begin
              valid_q[idx_q] <= 1'b1;
              ack_q          <= 1'b1;
              state_q        <= RESP;
            end else begin
              m_req_q <= 1'b1;
              m_adr_q <= 32'({tag_q, idx_q, cnt_nxt}) << BO;
              state_q <= REFILL_REQ;
            end
          end
        end
        WT_REQ: begin
          if (m_gnt) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            ack_q   <= 1'b1;
            resp_q  <= '0;
            state_q <= IDLE;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp     = resp_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_adr    = m_adr_q;
  assign m_wdata  = m_wdata_q;
  assign m_strobe = m_strobe_q;
endmodule

// File: tb/tb_cache_dm_wt.sv
// Scoreboarded bench: a backing-memory responder with random waits, expected
// responses queued at request time and popped on every ack.
module tb_cache_dm_wt;
  logic        clk, rst, r_v, w_v;
  logic [31:0] adr, data, resp, m_adr, m_wdata, m_rdata;
  logic [3:0]  strobe, m_strobe;
  logic        ack, err, m_req, m_we, m_gnt, m_rvalid;

  cache_dm_wt dut (
    .clk(clk), .rst(rst), .r_v(r_v), .w_v(w_v), .adr(adr), .data(data),
    .strobe(strobe), .resp(resp), .ack(ack), .err(err), .m_req(m_req),
    .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata), .m_strobe(m_strobe),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic c; logic e; logic [31:0] d;} exp_t;
  exp_t        exp_q[$];
  exp_t        mx;
  logic [31:0] bmem[logic [31:0]];
  logic [31:0] rdadr_q[$];
  int          total = 0, bad = 0, nrd = 0, nwr = 0;
  logic        lg_we;
  logic [31:0] lg_adr, lg_wdata;
  logic [3:0]  lg_strb;
  logic        pend = 0, stray = 0;
  logic [31:0] padr;
  int          gw = 0, rw = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    bmem[a] = w;
  endtask

  // Backing memory: one transaction at a time, random grant and data waits.
  initial begin
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(posedge clk); #1;
      m_gnt = 0; m_rvalid = 0;
      if (rst) begin
        pend = 0; gw = 0;
      end else if (pend) begin
        if (rw == 0) begin m_rvalid = 1; m_rdata = mem_rd(padr); pend = 0; end
        else rw--;
      end else if (stray) begin
        m_rvalid = 1; m_rdata = 32'hDEADBEEF; stray = 0;
      end else if (m_req) begin
        if (gw == 0) begin
          m_gnt = 1; gw = $urandom_range(0, 2);
          lg_we = m_we; lg_adr = m_adr; lg_wdata = m_wdata; lg_strb = m_strobe;
          if (m_we) begin nwr++; mem_wr(m_adr, m_wdata, m_strobe); end
          else begin
            nrd++; rdadr_q.push_back(m_adr);
            pend = 1; padr = m_adr; rw = $urandom_range(0, 2);
          end
        end else gw--;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ack) begin
        if (exp_q.size() == 0) chk("spur_ack", ack, 0);
        else begin
          mx = exp_q.pop_front();
          chk("err", err, mx.e);
          if (mx.c) chk("resp", resp, mx.d);
        end
      end
    end
  end

  // e_rd/e_wr < 0 skip the traffic count; e_lat 0 skips the latency check.
  task automatic req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic e_err,
                     input logic e_chk, input logic [31:0] e_d, input int e_rd,
                     input int e_wr, input int e_lat);
    int r0, w0, cyc;
    r0 = nrd; w0 = nwr; cyc = 0;
    exp_q.push_back({e_chk, e_err, e_d});
    r_v = rd; w_v = wr; adr = a; data = d; strobe = s;
    do begin @(posedge clk); #1; cyc++; end while (!ack && cyc < 300);
    if (!ack) begin chk({tag, "_timeout"}, 0, 1); exp_q.delete(); end
    r_v = 0; w_v = 0;
    if (e_rd >= 0) chk({tag, "_nrd"}, 64'(nrd - r0), 64'(e_rd));
    if (e_wr >= 0) chk({tag, "_nwr"}, 64'(nwr - w0), 64'(e_wr));
    if (e_lat > 0) chk({tag, "_lat"}, 64'(cyc), 64'(e_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r0, k;
    rst = 1; r_v = 0; w_v = 0; adr = 0; data = 0; strobe = 0;
    bmem[32'h100] = 32'h11111111; bmem[32'h104] = 32'h22222222;
    bmem[32'h108] = 32'h33333333; bmem[32'h10C] = 32'h44444444;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ack", ack, 0);    chk("rst_err", err, 0);
    chk("rst_mreq", m_req, 0); chk("rst_mwe", m_we, 0);
    chk("rst_resp", resp, 0);  chk("rst_madr", m_adr, 0);
    chk("rst_mwdata", m_wdata, 0); chk("rst_mstrb", m_strobe, 0);

    rdadr_q.delete();
    req("cold", 1, 0, 32'h100, 0, 0, 0, 1, 32'h11111111, 4, 0, 0);
    for (int i = 0; i < 4; i++)
      chk("fill_adr", (rdadr_q.size() > i) ? rdadr_q[i] : 32'hFFFFFFFF, 32'h100 + 32'(4*i));
    req("hit", 1, 0, 32'h108, 0, 0, 0, 1, 32'h33333333, 0, 0, 1);

    req("wr_hit", 0, 1, 32'h104, 32'hAABBCCDD, 4'b0011, 0, 0, 0, 0, 1, 0);
    chk("wr_we", lg_we, 1); chk("wr_adr", lg_adr, 32'h104);
    chk("wr_data", lg_wdata, 32'hAABBCCDD); chk("wr_strb", lg_strb, 4'b0011);
    req("rd_merged", 1, 0, 32'h104, 0, 0, 0, 1, 32'h2222CCDD, 0, 0, 1);

    req("wr_miss", 0, 1, 32'h2000, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 1, 0);
    req("rd_wmiss", 1, 0, 32'h2000, 0, 0, 0, 1, 32'hCAFEF00D, 4, 0, 0);

    req("mis_rd", 1, 0, 32'h102, 0, 0, 1, 0, 0, 0, 0, 1);
    req("mis_wr", 0, 1, 32'h10A, 32'h1, 4'hF, 1, 0, 0, 0, 0, 1);
    req("both", 1, 1, 32'h100, 32'h1, 4'hF, 1, 0, 0, 0, 0, 1);
    req("wr_s0", 0, 1, 32'h108, 32'h12345678, 4'h0, 0, 0, 0, 0, 0, 1);
    req("rd_s0", 1, 0, 32'h108, 0, 0, 0, 1, 32'h33333333, 0, 0, 1);

    // Reset while a refill is in flight, then inject a stray rvalid.
    r0 = nrd; k = 0;
    r_v = 1; adr = 32'h300;
    while (nrd == r0 && k < 50) begin @(posedge clk); #1; k++; end
    chk("rst_gnt", 64'(nrd - r0), 1);
    @(posedge clk); #1;
    rst = 1; r_v = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("mid_rst_mreq", m_req, 0); chk("mid_rst_ack", ack, 0);
    stray = 1;
    repeat (6) @(posedge clk);
    #1;
    req("reread", 1, 0, 32'h300, 0, 0, 0, 1, mem_rd(32'h300), 4, 0, 0);

    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'h1100 : 32'h100;
      req("alias", 1, 0, a, 0, 0, 0, 1, mem_rd(a), 4, 0, 0);
    end

    for (int i = 0; i < 16; i++) begin
      a = (($urandom_range(0, 1) == 1) ? 32'h1100 : 32'h100) + 32'($urandom_range(0, 3)) * 4;
      if ($urandom_range(0, 2) == 0)
        req("rnd_wr", 0, 1, a, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0, 0, -1, 0);
      else
        req("rnd_rd", 1, 0, a, 0, 0, 0, 1, mem_rd(a), -1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
